// File: rtl/el2_exu_mul_result_collector.sv
// Reassembles FLIT_BITS-wide NoC flits, LSB first, into 32-bit multiply results and queues them in a small FIFO.
// Define MUL_RCV_FRAME_CHECK_EN to build in in_last framing checks and the sticky err output.
module el2_exu_mul_result_collector #(
    parameter int FLIT_BITS = 8,
    parameter int DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [FLIT_BITS-1:0]     in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     res_valid,
    output logic [31:0]              res_data,
    input  logic                     res_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef MUL_RCV_FRAME_CHECK_EN
    ,
    output logic                     err
`endif
);

    localparam int BEATS  = 32 / FLIT_BITS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    logic [BEAT_W-1:0] beat;
    logic [31:0]       partial;
    logic [31:0]       assembled;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;

    logic accept;
    logic final_beat;
    logic frame_bad;
    logic push;
    logic pop;

    assign in_ready   = (count != FULL_CNT);
    assign res_valid  = (count != '0);
    assign fifo_count = count;
    assign res_data   = mem[rptr];

    // A flit arriving alongside flush is dropped, as is any pop in that cycle.
    assign accept     = in_valid & in_ready & ~flush;
    assign pop        = res_valid & res_ready & ~flush;
    assign final_beat = (beat == LAST_BEAT);

`ifdef MUL_RCV_FRAME_CHECK_EN
    assign frame_bad = accept & (in_last != final_beat);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_bad      = 1'b0;
`endif

    assign push = accept & final_beat & ~frame_bad;

    always_comb begin
        assembled = partial;
        assembled[int'(beat) * FLIT_BITS +: FLIT_BITS] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat    <= '0;
            partial <= '0;
        end else if (flush) begin
            beat    <= '0;
            partial <= '0;
        end else if (accept) begin
            if (final_beat || frame_bad) begin
                beat    <= '0;
                partial <= '0;
            end else begin
                beat    <= beat + 1'b1;
                partial <= assembled;
            end
        end
    end

    // Entries are reset so res_data reads zero until the first result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= assembled;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef MUL_RCV_FRAME_CHECK_EN
    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (frame_bad) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
